// File: rtl/p18_pkg.sv
// Shared definitions for the breakout game-state controller and the painters.
// Holds the controller state encoding, default frame timing constants and
// the colour constants the painters use when drawing state-dependent items.
package p18_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_LOST,
    ST_CLEARED,
    ST_OVER
  } state_e;

  localparam logic [1:0] START_LIVES_DEF  = 2'd3;
  localparam logic [6:0] SERVE_FRAMES_DEF = 7'd60;
  localparam logic [6:0] LOST_FRAMES_DEF  = 7'd90;
  localparam int         FLASH_SHIFT_DEF  = 3;

  // 12-bit RGB (4:4:4) colours shared with the painters
  localparam logic [11:0] COLOR_BG     = 12'h000;
  localparam logic [11:0] COLOR_PADDLE = 12'hFFF;
  localparam logic [11:0] COLOR_LIVES  = 12'h0F0;
  localparam logic [11:0] COLOR_FLASH  = 12'hF00;

endpackage

// File: rtl/p18_event_latch.sv
// Sticky pending-event cell.
// Ports:
//   clk, nRst   : clock, asynchronous active-low reset
//   set_i       : event pulse
//   en_i        : event accepted only while high; flag forced to 0 otherwise
//   consume_i   : frame boundary, clears the flag
//   pend_o      : pending flag, including an event arriving this very cycle
module p18_event_latch (
  input  logic clk,
  input  logic nRst,
  input  logic set_i,
  input  logic en_i,
  input  logic consume_i,
  output logic pend_o
);

  logic pend_q, pend_d;

  // An event on the consuming cycle is seen immediately, not a frame later.
  assign pend_o = en_i & (pend_q | set_i);

  always_comb begin
    pend_d = pend_q;
    if (!en_i)          pend_d = 1'b0;
    else if (consume_i) pend_d = 1'b0;
    else if (set_i)     pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

endmodule

// File: rtl/p18_game_state.sv
// Frame-synchronous game-state controller (serve / play / lost / cleared /
// game over) feeding the lives painter. Visible state only moves on
// frame_start; asynchronous game events are latched until then.
// Ports:
//   clk, nRst       : pixel clock, asynchronous active-low reset
//   frame_start     : one-cycle pulse per frame
//   start_btn       : synchronised start button level
//   ball_lost       : pulse, ball left the bottom edge
//   bricks_cleared  : pulse, last brick destroyed
//   lives           : spare lives for the painter
//   ball_active     : ball may move/collide
//   ball_reset      : ball held at serve position
//   game_over       : high in OVER
//   flash           : blink enable while LOST or OVER
//   level_up        : one-cycle pulse when a new level's serve begins
module p18_game_state
  import p18_pkg::*;
#(
  parameter logic [1:0] START_LIVES  = START_LIVES_DEF,
  parameter logic [6:0] SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter logic [6:0] LOST_FRAMES  = LOST_FRAMES_DEF,
  parameter int         FLASH_SHIFT  = FLASH_SHIFT_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       frame_start,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [1:0] lives,
  output logic       ball_active,
  output logic       ball_reset,
  output logic       game_over,
  output logic       flash,
  output logic       level_up
);

  state_e                 state_q, state_d;
  logic [1:0]             lives_q, lives_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [FLASH_SHIFT:0]   fcnt_q;
  logic                   btn_q;
  logic                   level_up_q, level_up_d;
  logic                   start_pend, lost_pend, clr_pend;
  logic                   start_en, play_en;

  assign start_en = (state_q == ST_IDLE) || (state_q == ST_OVER);
  assign play_en  = (state_q == ST_PLAY);

  p18_event_latch u_start (
    .clk(clk), .nRst(nRst), .set_i(start_btn & ~btn_q), .en_i(start_en),
    .consume_i(frame_start), .pend_o(start_pend)
  );

  p18_event_latch u_lost (
    .clk(clk), .nRst(nRst), .set_i(ball_lost), .en_i(play_en),
    .consume_i(frame_start), .pend_o(lost_pend)
  );

  p18_event_latch u_clr (
    .clk(clk), .nRst(nRst), .set_i(bricks_cleared), .en_i(play_en),
    .consume_i(frame_start), .pend_o(clr_pend)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    level_up_d = 1'b0;
    if (frame_start) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_pend) begin
            lives_d = START_LIVES;
            cnt_d   = SERVE_FRAMES - 7'd1;
            state_d = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (cnt_q == 7'd0) state_d = ST_PLAY;
          else               cnt_d   = cnt_q - 7'd1;
        end
        ST_PLAY: begin
          // Clearing the level wins over a loss in the same frame.
          if (clr_pend) begin
            cnt_d   = LOST_FRAMES - 7'd1;
            state_d = ST_CLEARED;
          end else if (lost_pend && lives_q == 2'd0) begin
            state_d = ST_OVER;
          end else if (lost_pend) begin
            lives_d = lives_q - 2'd1;
            cnt_d   = LOST_FRAMES - 7'd1;
            state_d = ST_LOST;
          end
        end
        ST_LOST, ST_CLEARED: begin
          if (cnt_q == 7'd0) begin
            cnt_d      = SERVE_FRAMES - 7'd1;
            state_d    = ST_SERVE;
            level_up_d = (state_q == ST_CLEARED);
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      lives_q    <= 2'd0;
      cnt_q      <= 7'd0;
      fcnt_q     <= '0;
      btn_q      <= 1'b0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      btn_q      <= start_btn;
      level_up_q <= level_up_d;
      if (frame_start) fcnt_q <= fcnt_q + {{FLASH_SHIFT{1'b0}}, 1'b1};
    end
  end

  assign lives       = lives_q;
  assign ball_active = (state_q == ST_PLAY);
  assign ball_reset  = (state_q != ST_PLAY);
  assign game_over   = (state_q == ST_OVER);
  assign flash       = fcnt_q[FLASH_SHIFT] &
                       ((state_q == ST_LOST) || (state_q == ST_OVER));
  assign level_up    = level_up_q;

endmodule

// File: tb/tb_p18_game_state.sv
// Directed bench for the game-state controller: a table of steps
// (stimulus, frame count, expected state/lives) plus hand-written
// sequences for level_up, flash, same-cycle start and mid-game reset.
module tb_p18_game_state;

  typedef enum int {E_IDLE, E_SERVE, E_PLAY, E_LOST, E_CLR, E_OVER} est_e;

  typedef struct {
    logic       btn;
    logic       lost;
    logic       clr;
    int         frames;
    est_e       st;
    logic [1:0] lv;
  } vec_t;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       frame_start = 1'b0;
  logic       start_btn = 1'b0;
  logic       ball_lost = 1'b0;
  logic       bricks_cleared = 1'b0;
  logic [1:0] lives;
  logic       ball_active, ball_reset, game_over, flash, level_up;

  int total = 0;
  int bad = 0;
  int fcnt = 0;

  always #5 clk = ~clk;

  p18_game_state dut (
    .clk(clk), .nRst(nRst), .frame_start(frame_start), .start_btn(start_btn),
    .ball_lost(ball_lost), .bricks_cleared(bricks_cleared), .lives(lives),
    .ball_active(ball_active), .ball_reset(ball_reset), .game_over(game_over),
    .flash(flash), .level_up(level_up)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    fcnt++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk_state(input string tag, input est_e st, input logic [1:0] lv);
    logic exp_flash;
    exp_flash = ((st == E_LOST) || (st == E_OVER)) ? fcnt[3] : 1'b0;
    chk({tag, ".lives"},    lives,       lv);
    chk({tag, ".active"},   ball_active, st == E_PLAY);
    chk({tag, ".reset"},    ball_reset,  st != E_PLAY);
    chk({tag, ".over"},     game_over,   st == E_OVER);
    chk({tag, ".flash"},    flash,       exp_flash);
    chk({tag, ".level_up"}, level_up,    0);
  endtask

  vec_t tbl1[16];
  vec_t tbl2[9];

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    start_btn = v.btn; ball_lost = v.lost; bricks_cleared = v.clr;
    @(negedge clk);
    ball_lost = 1'b0; bricks_cleared = 1'b0;
    frames(v.frames);
    chk_state($sformatf("%s[%0d]", tag, idx), v.st, v.lv);
  endtask

  initial begin
    int toggles;
    logic prev;

    //         btn   lost  clr   frames st       lives
    tbl1[0]  = '{1'b1, 1'b0, 1'b0, 1,  E_SERVE, 2'd3};
    tbl1[1]  = '{1'b0, 1'b0, 1'b0, 59, E_SERVE, 2'd3};
    tbl1[2]  = '{1'b0, 1'b0, 1'b0, 1,  E_PLAY,  2'd3};
    tbl1[3]  = '{1'b0, 1'b1, 1'b0, 1,  E_LOST,  2'd2};
    tbl1[4]  = '{1'b0, 1'b0, 1'b0, 89, E_LOST,  2'd2};
    tbl1[5]  = '{1'b0, 1'b0, 1'b0, 1,  E_SERVE, 2'd2};
    tbl1[6]  = '{1'b0, 1'b1, 1'b0, 59, E_SERVE, 2'd2};
    tbl1[7]  = '{1'b0, 1'b0, 1'b0, 1,  E_PLAY,  2'd2};
    tbl1[8]  = '{1'b0, 1'b1, 1'b0, 1,  E_LOST,  2'd1};
    tbl1[9]  = '{1'b0, 1'b1, 1'b0, 90, E_SERVE, 2'd1};
    tbl1[10] = '{1'b0, 1'b0, 1'b0, 60, E_PLAY,  2'd1};
    tbl1[11] = '{1'b0, 1'b1, 1'b0, 1,  E_LOST,  2'd0};
    tbl1[12] = '{1'b0, 1'b0, 1'b0, 90, E_SERVE, 2'd0};
    tbl1[13] = '{1'b0, 1'b0, 1'b0, 60, E_PLAY,  2'd0};
    tbl1[14] = '{1'b0, 1'b1, 1'b1, 1,  E_CLR,   2'd0};
    tbl1[15] = '{1'b0, 1'b0, 1'b0, 89, E_CLR,   2'd0};

    tbl2[0]  = '{1'b0, 1'b0, 1'b0, 60, E_PLAY,  2'd0};
    tbl2[1]  = '{1'b1, 1'b1, 1'b0, 1,  E_OVER,  2'd0};
    tbl2[2]  = '{1'b1, 1'b0, 1'b0, 20, E_OVER,  2'd0};
    tbl2[3]  = '{1'b0, 1'b0, 1'b0, 1,  E_OVER,  2'd0};
    tbl2[4]  = '{1'b1, 1'b0, 1'b0, 1,  E_SERVE, 2'd3};
    tbl2[5]  = '{1'b0, 1'b0, 1'b0, 60, E_PLAY,  2'd3};
    tbl2[6]  = '{1'b0, 1'b1, 1'b0, 1,  E_LOST,  2'd2};
    tbl2[7]  = '{1'b0, 1'b0, 1'b0, 90, E_SERVE, 2'd2};
    tbl2[8]  = '{1'b0, 1'b0, 1'b0, 60, E_PLAY,  2'd2};

    // reset state
    repeat (3) @(negedge clk);
    chk_state("reset", E_IDLE, 2'd0);
    nRst = 1'b1;
    frames(2);
    chk_state("idle_nostart", E_IDLE, 2'd0);

    for (int i = 0; i < 16; i++) run_vec("t1", i, tbl1[i]);

    // final CLEARED frame: level_up for exactly one cycle, lives kept
    frame();
    chk("lvlup.pulse", level_up, 1);
    chk("lvlup.serve_reset", ball_reset, 1);
    chk("lvlup.lives", lives, 0);
    @(negedge clk);
    chk("lvlup.one_cycle", level_up, 0);

    for (int i = 0; i < 2; i++) run_vec("t2", i, tbl2[i]);

    // flash in OVER: follows frame counter bit 3, 2 toggles per 16 frames
    toggles = 0;
    prev = flash;
    for (int i = 0; i < 16; i++) begin
      frame();
      chk($sformatf("flash[%0d]", i), flash, fcnt[3]);
      if (flash != prev) toggles++;
      prev = flash;
    end
    chk("flash.toggles", toggles, 2);

    for (int i = 2; i < 9; i++) run_vec("t2", i, tbl2[i]);

    // mid-PLAY reset with an unconsumed loss pending
    @(negedge clk) ball_lost = 1'b1;
    @(negedge clk) ball_lost = 1'b0;
    #2 nRst = 1'b0;
    #1;
    chk("arst.lives", lives, 0);
    chk("arst.reset", ball_reset, 1);
    chk("arst.active", ball_active, 0);
    @(negedge clk) nRst = 1'b1;
    fcnt = 0;
    frames(2);
    chk_state("post_rst", E_IDLE, 2'd0);

    // start edge on the very cycle of frame_start is taken in that update
    @(negedge clk) begin start_btn = 1'b1; frame_start = 1'b1; end
    @(negedge clk) frame_start = 1'b0;
    fcnt++;
    chk_state("same_cycle", E_SERVE, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p18_game_state.md
Name: p18_game_state

Overview:
- Frame-synchronous game-state controller for the breakout-style game. It sits directly upstream of the lives painter.
- Owns the spare-lives count fed to the painter's `lives` input, plus serve/play/lost/game-over sequencing.
- All visible state changes occur only on `frame_start`, so the painters see stable values across a whole frame.
- Ball, brick and input logic send events asynchronously to the frame; this block latches them until the next frame boundary.

Parameters:
- START_LIVES, 2'd3: spare balls loaded at game start (number of paddles the painter draws).
- SERVE_FRAMES, 7'd60: frames the ball is held in reset before play starts.
- LOST_FRAMES, 7'd90: frames of pause after a ball is lost or the level is cleared.
- FLASH_SHIFT, 3: `flash` toggles every 2^FLASH_SHIFT frames while in LOST or OVER.

Ports:
- clk, input, 1: pixel clock.
- nRst, input, 1: asynchronous active-low reset.
- frame_start, input, 1: one-cycle pulse at the first vblank line.
- start_btn, input, 1: start button, already synchronised, level.
- ball_lost, input, 1: one-cycle pulse when the ball passes the bottom edge.
- bricks_cleared, input, 1: one-cycle pulse when the last brick is destroyed.
- lives, output, 2: spare lives; drives the lives painter.
- ball_active, output, 1: ball may move and collide.
- ball_reset, output, 1: ball held at the serve position.
- game_over, output, 1: high in OVER.
- flash, output, 1: blink enable for the painters.
- level_up, output, 1: one-cycle pulse when a new level's serve begins.

Behaviour:
- Reset (asynchronous, any time, including mid-game):
  - state=IDLE, lives=0, frame counter=0.
  - All pending flags = 0; start_btn edge register = 0.
  - ball_active=0, ball_reset=1, game_over=0, flash=0, level_up=0.
- Start event: a rising edge of start_btn (1-cycle delayed sample). It sets start_pend only in IDLE or OVER; in other states it is ignored.
- Ball and brick events:
  - ball_lost sets lost_pend only in PLAY.
  - bricks_cleared sets clr_pend only in PLAY.
  - Outside PLAY both pulses are ignored and their pending flags are held at 0.
- Timing rule: state, lives and the frame counter update only on a cycle where frame_start=1. Pending flags are consumed (cleared) on that same cycle.
- Same-cycle event and frame_start: an event arriving on the same cycle as frame_start is taken into account in that update (flag set and consumed in one cycle).
- States and transitions (evaluated on frame_start):
  - IDLE: if start_pend, then lives<=START_LIVES, cnt<=SERVE_FRAMES-1, go to SERVE.
  - SERVE: ball_reset=1. If cnt==0 go to PLAY; else cnt<=cnt-1.
  - PLAY: ball_active=1, ball_reset=0. Checks in priority order:
    - if clr_pend: cnt<=LOST_FRAMES-1, go to CLEARED. Clear takes priority over a same-frame loss.
    - else if lost_pend and lives==0: go to OVER.
    - else if lost_pend: lives<=lives-1, cnt<=LOST_FRAMES-1, go to LOST.
  - LOST: ball_active=0, ball_reset=1. If cnt==0: cnt<=SERVE_FRAMES-1, go to SERVE; else decrement.
  - CLEARED: same as LOST, but the exit to SERVE asserts level_up for exactly that one clk cycle. lives is unchanged.
  - OVER: game_over=1, ball_reset=1, lives stays 0. If start_pend: lives<=START_LIVES, cnt<=SERVE_FRAMES-1, go to SERVE.
- Output timing: outputs are registered or decoded from registered state, so they change on the cycle after the frame_start sample.
- flash:
  - A free-running frame counter increments on every frame_start.
  - flash = bit FLASH_SHIFT of that counter, while in LOST or OVER; 0 elsewhere.
- Width rules: lives never underflows (the lives==0 check precedes the decrement). cnt is 7 bits; parameters must be between 1 and 127.

Decomposition:
- Shared package p18_pkg holds:
  - the state enum (IDLE, SERVE, PLAY, LOST, CLEARED, OVER);
  - default frame constants;
  - the color constants shared with the painters.
- One sub-module, p18_event_latch: the sticky pending-flag cell (set, clear-on-consume, enable). It is instantiated three times (start, lost, cleared).

Test Plan:
- Reset then start_btn rising edge, then frame_start → SERVE and lives=3. After 60 further frame_starts → PLAY with ball_active=1.
- In PLAY, ball_lost mid-frame, then frame_start → lives 3→2, state LOST, ball_active=0. After 90 frames → SERVE, then 60 frames → PLAY.
- lives=0 in PLAY, then ball_lost → game_over=1 on the next frame_start. flash toggles every 8 frames. start_btn edge → SERVE with lives=3.
- ball_lost and bricks_cleared in the same frame → CLEARED, lives unchanged. level_up pulses exactly one cycle when entering SERVE.
- ball_lost pulse during SERVE or LOST → ignored; no lives change. start_btn held high through OVER entry → no restart until a new rising edge.
- nRst asserted mid-PLAY with lives=2 → immediately IDLE, lives=0, ball_reset=1. No stale pending event takes effect after release.
